// File: rtl/display_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment display controller:
// digit count, blank codes and the active-low hex segment table (gfedcba).
package display_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Entry n is the active-low code for hex digit n (index 15 listed first).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/hex_7seg.sv
// Combinational nibble to active-low 7-segment code (seg[0]=a .. seg[6]=g).
module hex_7seg
    import display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/controlador_display.sv
// Captures the CPU OUT value and scans it as 4 hex digits on a common-anode
// display, with optional leading-zero blanking and blinking while halted.
module controlador_display
    import display_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int BLINK_DIV   = 64,
    parameter int BLANK_ZEROS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic [15:0] data,
    input  logic        halt,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int RND_W = $clog2(BLINK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(BLINK_DIV - 1);

    logic [15:0]      valor_q;
    logic             escrito_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       idx_q;
    logic [RND_W-1:0] rounds_q;
    logic             blink_on_q;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       an_q, an_d;

    logic [3:0]       nibs [DIGITS];
    logic [DIGITS-1:0] zero_from;
    logic [3:0]       nib;
    logic [6:0]       hex_seg;
    logic             scan_tick;
    logic             scan_wrap;
    logic             blank;

    // zero_from[i]: every nibble from digit i up to the top one is zero.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign nibs[gi]      = valor_q[4*gi +: 4];
            assign zero_from[gi] = ~|valor_q[4*DIGITS-1 : 4*gi];
        end
    endgenerate

    assign nib       = nibs[idx_q];
    assign scan_tick = (div_q == DIV_LAST);
    assign scan_wrap = scan_tick && (idx_q == 2'd3);

    hex_7seg u_hex (
        .nib_i (nib),
        .seg_o (hex_seg)
    );

    always_comb begin
        blank = ((BLANK_ZEROS != 0) && (idx_q != 2'd0) && zero_from[idx_q]) || !blink_on_q;
        an_d  = blank ? AN_OFF  : ~(4'b0001 << idx_q);
        seg_d = blank ? SEG_OFF : hex_seg;
        dp_d  = !((idx_q == 2'd0) && escrito_q && !blank);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valor_q    <= 16'h0000;
            escrito_q  <= 1'b0;
            div_q      <= '0;
            idx_q      <= 2'd0;
            rounds_q   <= '0;
            blink_on_q <= 1'b1;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
            an_q       <= AN_OFF;
        end else begin
            if (write) begin
                valor_q   <= data;
                escrito_q <= 1'b1;
            end

            if (scan_tick) begin
                div_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                div_q <= div_q + 1'b1;
            end

            // Outside halt the blink phase is held "on" so it restarts cleanly.
            if (!halt) begin
                rounds_q   <= '0;
                blink_on_q <= 1'b1;
            end else if (scan_wrap) begin
                if (rounds_q == RND_LAST) begin
                    rounds_q   <= '0;
                    blink_on_q <= ~blink_on_q;
                end else begin
                    rounds_q <= rounds_q + 1'b1;
                end
            end

            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_controlador_display.sv
// Directed bench for controlador_display: three instances (blanking on/off,
// fast blink) share clock, reset and write bus; halt is per-instance.
module tb_controlador_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write = 1'b0;
    logic [15:0] data = 16'h0000;
    logic        halt_ab = 1'b0;
    logic        halt_c = 1'b0;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic [3:0] an_a, an_b, an_c;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    logic [3:0] ea_an [4];
    logic [6:0] ea_seg [4];
    logic       ea_dp [4];
    logic [3:0] eb_an [4];
    logic [6:0] eb_seg [4];
    logic       eb_dp [4];

    always #5 clk = ~clk;

    controlador_display #(.CLK_DIV(4), .BLINK_DIV(64), .BLANK_ZEROS(1)) u_dut_a (
        .clk(clk), .reset(reset), .write(write), .data(data), .halt(halt_ab),
        .seg(seg_a), .dp(dp_a), .an(an_a)
    );

    controlador_display #(.CLK_DIV(4), .BLINK_DIV(64), .BLANK_ZEROS(0)) u_dut_b (
        .clk(clk), .reset(reset), .write(write), .data(data), .halt(halt_ab),
        .seg(seg_b), .dp(dp_b), .an(an_b)
    );

    controlador_display #(.CLK_DIV(2), .BLINK_DIV(2), .BLANK_ZEROS(1)) u_dut_c (
        .clk(clk), .reset(reset), .write(write), .data(data), .halt(halt_c),
        .seg(seg_c), .dp(dp_c), .an(an_c)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Each step shows digit ((cyc-1)/4) mod 4 on the CLK_DIV=4 instances.
    task automatic scan_check(input int n);
        for (int i = 0; i < n; i++) begin
            int d;
            step();
            d = ((cyc - 1) >> 2) & 3;
            check_eq($sformatf("an_a[%0d]", cyc),  {12'h0, an_a},  {12'h0, ea_an[d]});
            check_eq($sformatf("seg_a[%0d]", cyc), {9'h0, seg_a},  {9'h0, ea_seg[d]});
            check_eq($sformatf("dp_a[%0d]", cyc),  {15'h0, dp_a},  {15'h0, ea_dp[d]});
            check_eq($sformatf("an_b[%0d]", cyc),  {12'h0, an_b},  {12'h0, eb_an[d]});
            check_eq($sformatf("seg_b[%0d]", cyc), {9'h0, seg_b},  {9'h0, eb_seg[d]});
            check_eq($sformatf("dp_b[%0d]", cyc),  {15'h0, dp_b},  {15'h0, eb_dp[d]});
        end
    endtask

    // Fast instance: digit ((cyc-1)/2) mod 4, value 8888 so every digit lights.
    task automatic blink_check(input int n, input int off_lo, input int off_hi);
        for (int i = 0; i < n; i++) begin
            int d;
            logic lit;
            step();
            d   = ((cyc - 1) >> 1) & 3;
            lit = !(cyc >= off_lo && cyc <= off_hi);
            check_eq($sformatf("blink_an[%0d]", cyc), {12'h0, an_c},
                     {12'h0, (lit ? ~(4'b0001 << d) : 4'b1111)});
            check_eq($sformatf("blink_seg[%0d]", cyc), {9'h0, seg_c},
                     {9'h0, (lit ? 7'b0000000 : 7'b1111111)});
        end
    endtask

    initial begin
        // Reset held for two edges
        reset = 1'b1;
        step();
        step();
        $display("reset asserted, outputs after 2 edges an_a=%b seg_a=%b dp_a=%b", an_a, seg_a, dp_a);
        check_eq("rst_an_a",  {12'h0, an_a},  16'h000F);
        check_eq("rst_seg_a", {9'h0, seg_a},  16'h007F);
        check_eq("rst_dp_a",  {15'h0, dp_a}, 16'h0001);
        check_eq("rst_an_b",  {12'h0, an_b},  16'h000F);
        check_eq("rst_an_c",  {12'h0, an_c},  16'h000F);
        reset = 1'b0;
        cyc = 0;

        // Idle after reset: value 0, nothing written yet
        ea_an  = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        ea_seg = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
        ea_dp  = '{1'b1, 1'b1, 1'b1, 1'b1};
        eb_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        eb_seg = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
        eb_dp  = '{1'b1, 1'b1, 1'b1, 1'b1};
        $display("idle scan after reset, 16 cycles");
        scan_check(16);

        // Capture 1A2F; the write edge itself still shows the old value
        write = 1'b1;
        data  = 16'h1A2F;
        step();
        $display("write data=%h at cyc %0d", data, cyc);
        check_eq("lat_an_a",  {12'h0, an_a},  16'h000E);
        check_eq("lat_seg_a", {9'h0, seg_a},  16'h0040);
        check_eq("lat_dp_a",  {15'h0, dp_a}, 16'h0001);
        write = 1'b0;
        ea_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        ea_seg = '{7'b0001110, 7'b0100100, 7'b0001000, 7'b1111001};
        ea_dp  = '{1'b0, 1'b1, 1'b1, 1'b1};
        eb_an  = ea_an;
        eb_seg = ea_seg;
        eb_dp  = ea_dp;
        scan_check(16);

        // Write FFFF on the edge where idx goes 0 -> 1
        step();
        step();
        write = 1'b1;
        data  = 16'hFFFF;
        step();
        $display("write data=%h at cyc %0d (scan boundary)", data, cyc);
        check_eq("bnd_old_an",  {12'h0, an_a},  16'h000E);
        check_eq("bnd_old_seg", {9'h0, seg_a},  16'h000E);
        check_eq("bnd_old_dp",  {15'h0, dp_a}, 16'h0000);
        write = 1'b0;
        step();
        check_eq("bnd_new_an",  {12'h0, an_a},  16'h000D);
        check_eq("bnd_new_seg", {9'h0, seg_a},  16'h000E);
        check_eq("bnd_new_dp",  {15'h0, dp_a}, 16'h0001);

        // Leading-zero blanking on A, disabled on B
        write = 1'b1;
        data  = 16'h0030;
        step();
        $display("write data=%h at cyc %0d", data, cyc);
        write = 1'b0;
        step();
        step();
        ea_an  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        ea_seg = '{7'b1000000, 7'b0110000, 7'b1111111, 7'b1111111};
        ea_dp  = '{1'b0, 1'b1, 1'b1, 1'b1};
        eb_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        eb_seg = '{7'b1000000, 7'b0110000, 7'b1000000, 7'b1000000};
        eb_dp  = '{1'b0, 1'b1, 1'b1, 1'b1};
        scan_check(16);

        // Halt blink on the fast instance: 16 lit, 16 off, repeating
        write  = 1'b1;
        data   = 16'h8888;
        halt_c = 1'b1;
        step();
        $display("write data=%h, halt raised at cyc %0d", data, cyc);
        write = 1'b0;
        blink_check(47, 73, 88);
        blink_check(2, 105, 120);
        halt_c = 1'b0;
        step();
        $display("halt dropped during off phase at cyc %0d", cyc);
        blink_check(17, 1000, 1000);

        // Reset mid-scan while idx=2 and valor=BEEF, with a write in the reset cycle
        write = 1'b1;
        data  = 16'hBEEF;
        step();
        $display("write data=%h at cyc %0d", data, cyc);
        write = 1'b0;
        while (cyc < 137) step();
        check_eq("pre_rst_an",  {12'h0, an_a},  16'h000B);
        check_eq("pre_rst_seg", {9'h0, seg_a},  16'h0006);
        reset = 1'b1;
        write = 1'b1;
        data  = 16'h1234;
        step();
        $display("reset pulse with write data=%h at cyc %0d", data, cyc);
        check_eq("mid_rst_an_a",  {12'h0, an_a},  16'h000F);
        check_eq("mid_rst_seg_a", {9'h0, seg_a},  16'h007F);
        check_eq("mid_rst_dp_a",  {15'h0, dp_a}, 16'h0001);
        check_eq("mid_rst_an_b",  {12'h0, an_b},  16'h000F);
        check_eq("mid_rst_an_c",  {12'h0, an_c},  16'h000F);
        reset = 1'b0;
        write = 1'b0;
        cyc = 0;
        step();
        check_eq("post_rst_an_a",  {12'h0, an_a},  16'h000E);
        check_eq("post_rst_seg_a", {9'h0, seg_a},  16'h0040);
        check_eq("post_rst_dp_a",  {15'h0, dp_a}, 16'h0001);
        check_eq("post_rst_seg_b", {9'h0, seg_b},  16'h0040);
        check_eq("post_rst_dp_b",  {15'h0, dp_b}, 16'h0001);
        step();
        step();
        step();
        step();
        check_eq("post_rst_d1_an_a",  {12'h0, an_a},  16'h000F);
        check_eq("post_rst_d1_an_b",  {12'h0, an_b},  16'h000D);
        check_eq("post_rst_d1_seg_b", {9'h0, seg_b},  16'h0040);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/controlador_display.md
Name: controlador_display

Overview:
- Reader side of the CPU output path: captures the 16-bit OUT value on each OUT write strobe and shows it as 4 hex digits.
- Drives a time-multiplexed, common-anode 4-digit 7-segment display.
- Blinks the whole display while the CPU is halted.
- Sits at top level between the CPU's `saida`/`writeOUT` and the board pins.

Parameters:
- CLK_DIV, 50000, clock cycles each digit stays active (scan period per digit); legal range >= 2.
- BLINK_DIV, 64, full 4-digit scan rounds per blink half-period; legal range >= 1.
- BLANK_ZEROS, 1, when 1 leading zero digits 3..1 are blanked; digit 0 is never blanked.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- write  input  1  OUT write strobe (CPU writeOUT); data is sampled on any clk edge where write=1
- data  input  16  value being written to OUT
- halt  input  1  CPU in HLT state; enables blinking
- seg  output  7  segments, active-low, seg[0]=a … seg[6]=g
- dp  output  1  decimal point, active-low
- an  output  4  digit anodes, active-low, an[0]=least significant nibble

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - `reset` is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: valor=16'h0000, escrito=0, div=0, idx=0, rounds=0, blink_on=1, seg=7'b1111111, dp=1, an=4'b1111.
- Reset mid-operation:
  - Every register returns to its reset value on the same edge.
  - A write in the reset cycle is ignored.
- Capture:
  - On an edge with write=1, valor<=data and escrito<=1.
  - Back-to-back writes each overwrite valor; the last one wins.
- Scan:
  - div counts 0..CLK_DIV-1.
  - At terminal count, div<=0 and idx<=idx+1 mod 4 (3 wraps to 0).
- Blink:
  - rounds counts idx wrap events (3->0), range 0..BLINK_DIV-1.
  - At terminal count, rounds<=0 and blink_on<=~blink_on.
  - While halt=0: rounds<=0 and blink_on<=1 every cycle, so the display is steady and the blink phase restarts "on" when halt rises.
- Outputs are registered; each cycle they are computed from the current valor, idx, blink_on and escrito:
  - nib = valor[4*idx+3 : 4*idx].
  - blank = (BLANK_ZEROS && idx!=0 && all nibbles idx..3 == 0) || !blink_on.
  - an = blank ? 4'b1111 : ~(4'b0001<<idx).
  - seg = blank ? 7'b1111111 : hex code of nib.
  - dp = (idx==0 && escrito && !blank) ? 0 : 1.
- Latency: a write sampled at edge t shows on seg/an at edge t+1 for the digit currently selected; there is no wait for a scan boundary.
- Simultaneous write and scan tick: both take effect on the same edge. Outputs at the following edge use the new valor and the new idx.
- Hex codes (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Widths:
  - div is $clog2(CLK_DIV) bits.
  - rounds is $clog2(BLINK_DIV)+1 bits.
  - No overflow is possible: both counters reset at terminal count.

Decomposition:
- Shared package `display_pkg`:
  - DIGITS=4.
  - SEG_OFF=7'b1111111.
  - AN_OFF=4'b1111.
  - The 16-entry hex segment table as constants.
- One natural sub-module, `hex_7seg`: combinational 4-bit nibble to 7-bit active-low segment code, instantiated once and fed by the scan-selected nibble.

Test Plan:
- Reset: with CLK_DIV=4, BLANK_ZEROS=1, assert reset for 2 cycles then release, no writes -> an stays 1111 on digits 1..3 and only an=1110/seg=1000000 on digit 0; dp=1 throughout.
- Capture and scan: write data=16'h1A2F, then run 16 cycles -> an sequence 1110,1101,1011,0111 with 4 cycles each; seg respectively 0001110 (F), 0100100 (2), 0001000 (A), 1111001 (1); dp=0 only on digit 0.
- Leading-zero blanking: write 16'h0030 -> digits 3 and 2 have an=1111; digit 1 shows 0110000 (3); digit 0 shows 1000000 (0).
- Leading-zero blanking disabled: write 16'h0030 with BLANK_ZEROS=0 -> all four digits lit, showing 0,3,0,0.
- Write on scan boundary: write 16'hFFFF on the same edge that idx 0->1 -> the next edge shows an=1101, seg=0001110; there is no stale digit.
- Halt blink: with CLK_DIV=2, BLINK_DIV=2, halt=1 -> 16 cycles lit, 16 cycles all an=1111, repeating. Drop halt during the off phase -> display lit again from the next edge.
- Reset mid-scan: reset pulse while idx=2 and valor=16'hBEEF -> next edge an=1111, seg=1111111, dp=1. After release the display shows 0 on digit 0 and escrito=0.
